// File: rtl/pipe_flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_flow_ctrl_if
//   Handshake bundle between a pipe_flow_ctrl and its surroundings.
//   master : upstream/datapath/downstream side (drives in_valid, pipe_data,
//            out_ready; observes the controller outputs)
//   slave  : the flow controller itself
//   Signals:
//     in_valid / in_ready / issue  upstream issue handshake
//     pipe_data                    datapath result, LATENCY cycles after issue
//     out_valid / out_ready        downstream handshake
//     out_data                     head of output FIFO
//     outstanding                  in-flight plus buffered item count
// ---------------------------------------------------------------------------
interface pipe_flow_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             issue;
    logic [WIDTH-1:0] pipe_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] outstanding;

    modport master (
        output in_valid, pipe_data, out_ready,
        input  in_ready, issue, out_valid, out_data, outstanding
    );

    modport slave (
        input  in_valid, pipe_data, out_ready,
        output in_ready, issue, out_valid, out_data, outstanding
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_flow_ctrl
//   Credit-based flow controller for a fixed-latency, non-stallable datapath.
//   Operations are issued from a valid/ready upstream, tracked by a tag chain
//   of LATENCY flops, and their results captured into a BUF_DEPTH-entry FIFO
//   presented valid/ready downstream. Issue is only allowed while
//   in-flight + buffered < BUF_DEPTH, so the pipe can never overflow the FIFO.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : pipe_flow_ctrl_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module pipe_flow_ctrl #(
    parameter int WIDTH     = 8,
    parameter int LATENCY   = 4,
    parameter int BUF_DEPTH = 8,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    pipe_flow_ctrl_if.slave  bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [LATENCY-1:0] tag_q;
    logic [LATENCY:0]   tag_ext;
    logic [WIDTH-1:0]   mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;

    logic in_ready, out_valid, issue, pop, wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check uses registered state only; rst gates the outputs so
    // nothing is offered or accepted while reset is asserted.
    assign in_ready  = !rst && (outstanding_q < CNT_W'(BUF_DEPTH));
    assign out_valid = !rst && (count_q != '0);
    assign issue     = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
    // Tag at the end of the chain marks pipe_data as a live result.
    assign wr        = tag_q[LATENCY-1];

    // Shift with the new issue bit at the bottom; works for LATENCY == 1 too.
    assign tag_ext = {tag_q, issue};

    assign bus.in_ready    = in_ready;
    assign bus.issue       = issue;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = mem_q[rd_ptr_q];
    assign bus.outstanding = outstanding_q;

    always_comb begin
        wr_ptr_d      = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        if (wr && !pop)      count_d = count_q + CNT_W'(1);
        else if (!wr && pop) count_d = count_q - CNT_W'(1);
        if (issue && !pop)      outstanding_d = outstanding_q + CNT_W'(1);
        else if (!issue && pop) outstanding_d = outstanding_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            tag_q         <= tag_ext[LATENCY-1:0];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= bus.pipe_data;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr && count_q == CNT_W'(BUF_DEPTH)));
            assert (count_q <= outstanding_q);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_flow_ctrl
//   Randomized bench with a queue-based timing model: each issue becomes an
//   in-flight item due at cycle+LATENCY, then moves to a buffer queue that
//   drains on pops. Directed scenarios pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_pipe_flow_ctrl;
    localparam int W  = 8;
    localparam int L  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_flow_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    pipe_flow_ctrl #(.WIDTH(W), .LATENCY(L), .BUF_DEPTH(D), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_iss = 0;

    logic [W-1:0] op_data = '0;

    typedef struct { int t; logic [W-1:0] d; } fl_t;
    fl_t          infl [$];
    logic [W-1:0] bufq [$];
    logic [W-1:0] pipe_at [int];
    int           popped_d [$];
    int           popped_c [$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Datapath stand-in: issued operand emerges LATENCY cycles later, junk otherwise.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        bus.pipe_data = pipe_at.exists(cyc) ? pipe_at[cyc] : W'($urandom);
    end

    // Single compare process: check outputs, then advance the model by one cycle.
    always @(negedge clk) begin
        bit exp_rdy, exp_ov, do_pop, do_iss;
        exp_rdy = !rst && ((infl.size() + bufq.size()) < D);
        exp_ov  = !rst && (bufq.size() != 0);
        chk("in_ready",  int'(bus.in_ready),  int'(exp_rdy));
        chk("issue",     int'(bus.issue),     int'(bus.in_valid && exp_rdy));
        chk("out_valid", int'(bus.out_valid), int'(exp_ov));
        if (!rst) chk("outstanding", int'(bus.outstanding), infl.size() + bufq.size());
        if (exp_ov) chk("out_data", int'(bus.out_data), int'(bufq[0]));
        if (rst) begin
            infl.delete();
            bufq.delete();
        end else begin
            do_pop = exp_ov && bus.out_ready;
            do_iss = bus.in_valid && exp_rdy;
            if (do_pop) begin
                popped_d.push_back(int'(bufq[0]));
                popped_c.push_back(cyc);
                void'(bufq.pop_front());
            end
            if (infl.size() != 0 && infl[0].t == cyc) begin
                bufq.push_back(infl[0].d);
                void'(infl.pop_front());
            end
            if (do_iss) begin
                infl.push_back('{t: cyc + L, d: op_data});
                pipe_at[cyc + L] = op_data;
                n_iss++;
            end
        end
    end

    initial begin
        int t0, p0, n0, k;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.pipe_data = '0;

        // 1: reset holds everything quiet despite in_valid
        repeat (3) begin
            @(negedge clk);
            chk("t1_in_ready_rst",  int'(bus.in_ready),  0);
            chk("t1_issue_rst",     int'(bus.issue),     0);
            chk("t1_out_valid_rst", int'(bus.out_valid), 0);
        end
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_in_ready_rel",    int'(bus.in_ready),    1);
        chk("t1_outstanding_rel", int'(bus.outstanding), 0);

        // 2: single issue, latency LATENCY+1
        step();
        bus.in_valid = 1'b1;
        op_data = 8'hA5;
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("t2_out_valid", int'(bus.out_valid), (i == 5) ? 1 : 0);
            if (i == 5) chk("t2_out_data", int'(bus.out_data), 8'hA5);
            chk("t2_outstanding", int'(bus.outstanding), (i <= 5) ? 1 : 0);
        end

        // 3: 20 back-to-back issues at full rate
        step();
        t0 = cyc;
        p0 = popped_d.size();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            op_data = W'(i);
            @(negedge clk);
            chk("t3_in_ready", int'(bus.in_ready), 1);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (12) step();
        chk("t3_pop_count", popped_d.size() - p0, 20);
        for (int i = 0; i < 20 && p0 + i < popped_d.size(); i++) begin
            chk("t3_pop_data",  popped_d[p0 + i], i);
            chk("t3_pop_cycle", popped_c[p0 + i], t0 + L + 1 + i);
        end

        // 4: credit exhaustion with a stalled sink
        bus.out_ready = 1'b0;
        n0 = n_iss;
        repeat (12) begin
            bus.in_valid = 1'b1;
            op_data = W'(n_iss);
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t4_issues",      n_iss - n0, 8);
        chk("t4_in_ready",    int'(bus.in_ready), 0);
        chk("t4_outstanding", int'(bus.outstanding), 8);
        step();
        bus.out_ready = 1'b1;
        p0 = popped_d.size();
        @(negedge clk);
        chk("t4_in_ready_popcyc", int'(bus.in_ready), 0);
        step();
        @(negedge clk);
        chk("t4_in_ready_after", int'(bus.in_ready), 1);
        repeat (10) step();
        chk("t4_pop_count", popped_d.size() - p0, 8);
        for (int i = 0; i < 8 && p0 + i < popped_d.size(); i++)
            chk("t4_pop_data", popped_d[p0 + i], (n0 + i) & 8'hFF);

        // 5: 1000 random issues against random backpressure
        n0 = n_iss;
        k  = 0;
        while (n_iss - n0 < 1000 && k < 20000) begin
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            op_data       = W'($urandom);
            step();
            k++;
        end
        chk("t5_issued_in_budget", int'(n_iss - n0 >= 1000), 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("t5_drained_outstanding", int'(bus.outstanding), 0);
        chk("t5_drained_out_valid",   int'(bus.out_valid),   0);

        // 6: reset with 2 buffered and 3 in flight
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            op_data = W'(8'hE0 + i);
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_pre_outstanding", int'(bus.outstanding), 5);
        chk("t6_pre_out_valid",   int'(bus.out_valid),   1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        p0 = popped_d.size();
        repeat (6) begin
            @(negedge clk);
            chk("t6_out_valid_post",   int'(bus.out_valid),   0);
            chk("t6_outstanding_post", int'(bus.outstanding), 0);
            step();
        end
        bus.in_valid = 1'b1;
        op_data = 8'h3C;
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        chk("t6_pop_count", popped_d.size() - p0, 1);
        if (popped_d.size() > p0) chk("t6_pop_data", popped_d[p0], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
